romulus_pdi_formatter: RTL and testbench
========================================

// Module: romulus_pdi_formatter
// PURPOSE
//  Producer side of the datapath pdi/decrypt interface: accepts a byte-counted message stream (valid/ready),
//  emits BUSW-wide words grouped into 16-byte blocks, and appends Romulus padding (zero bytes, byte 15 = length)
//  to a short final block. It drives the per-byte decrypt mask so padding bytes are absorbed as plaintext.
//  It sits between the input FIFO and the datapath word interface; the controller pulses pdi_ready on each sen word.
// PARAMETERS
//  BUSW      32  bus width in bits (from romulus_config_pkg.v); BUSW/8 divides BLKBYTES
//  BLKBYTES  16  block size in bytes
// PORTS
//  clk            in   1              clock
//  rst            in   1              reset, synchronous, active-high
//  in_data        in   BUSW           message bytes; byte 0 at [BUSW-1:BUSW-8]
//  in_bytes       in   log2(BUSW/8)+1 valid bytes in word, MSB-aligned; 0 only for empty segment with in_last
//  in_last        in   1              last word of the message segment
//  in_dec         in   1              decrypt mode; sampled on the first accepted word of a segment
//  in_valid       in   1              input word valid
//  in_ready       out  1              input word accepted when in_valid & in_ready
//  pdi            out  BUSW           word to datapath
//  decrypt        out  BUSW/8         per-byte mask: 1 = ciphertext byte (datapath uses pdo)
//  pdi_valid      out  1              pdi/decrypt/flags valid
//  pdi_ready      in   1              datapath consumes word this cycle
//  blk_last_word  out  1              pdi is word BLKBYTES*8/BUSW-1 of its block
//  blk_partial    out  1              current block padded (constant over the block's words)
//  msg_done       out  1              pdi is the last word of the segment's final block
// BEHAVIOUR
//  - Reset: pdi=0, decrypt=0, pdi_valid=0, blk_last_word=0, blk_partial=0, msg_done=0; FSM=PASS; counters 0.
//  - Single registered output stage: in_ready = (state==PASS) & (~pdi_valid | pdi_ready); accepted word at
//    cycle t appears at t+1. Outputs hold stable while pdi_valid & ~pdi_ready. No combinational in->out path.
//  - wcnt (word in block, wraps at BLKBYTES*8/BUSW) and bcnt (message bytes in block, 0..BLKBYTES)
//    advance on every output word loaded.
//  - FSM PASS: load accepted word; bytes >= in_bytes forced to 0; decrypt[i] = dec & (i < in_bytes), where
//    mask bit BUSW/8-1 = byte 0. If in_last and block incomplete (bcnt+in_bytes < BLKBYTES) -> PAD, else stay.
//  - FSM PAD: in_ready=0; emit zero words with decrypt=0 until block ends; the last word of the block
//    carries len=bcnt in its LSB byte. Ends with msg_done -> PASS.
//  - If the partial word itself ends the block, len goes in its LSB byte, no PAD words, msg_done on that word.
//  - blk_partial=1 for every word of a block that receives padding; it is known at the first word only
//    when in_last arrives in the first word; the bench checks it on blk_last_word.
//  - Exactly full final block (len 16): no padding, blk_partial=0, msg_done on its last word.
//  - Empty segment (in_bytes=0, in_last): one all-zero block, len byte 0, decrypt=0, blk_partial=1.
//  - in_bytes < BUSW/8 with in_last=0: treated as in_last=1 (segment closed, padded).
//  - Reset mid-block or mid-PAD: everything discarded; next accepted word is word 0 of a new block.
// STRUCTURE
//  - romulus_config_pkg.v: BUSW, BLKBYTES, derived WPB=BLKBYTES*8/BUSW, byte-count widths, FSM encodings.
//  - Sub-module romulus_pad_word (combinational): in word, nbytes, dec, put_len, len -> padded word + mask.
//  - Top: FSM, wcnt/bcnt, output register, handshake.
// TESTING (BUSW=32, 4 words/block)
//  1. enc 16 B 00..0f, pdi_ready=1 -> 00010203,04050607,08090a0b,0c0d0e0f; decrypt=0; blk_partial=0; msg_done on word 3
//  2. enc 5 B (00010203, 04 in_bytes=1 last) -> 00010203,04000000,00000000,00000005; partial=1; in_ready=0 during pad
//  3. empty (in_bytes=0,in_last) -> 4x 00000000, decrypt=0, partial=1, msg_done on word 3
//  4. dec 6 B -> decrypt masks 1111,1100,0000,0000; last word 00000006; blk_partial=1
//  5. pdi_ready low 3 cycles mid-block -> pdi/decrypt stable, in_ready=0, no word lost or duplicated
//  6. rst asserted during PAD -> pdi_valid=0 next cycle; subsequent 16 B message output as in test 1

Source files
------------

// File: rtl/romulus_pdi_formatter_pkg.sv
// Shared sizing, types and FSM encoding for the Romulus PDI formatter.
// All widths derive from BUSW and BLKBYTES.
package romulus_pdi_formatter_pkg;

  localparam int BUSW     = 32;
  localparam int BLKBYTES = 16;
  localparam int BPW      = BUSW / 8;
  localparam int WPB      = BLKBYTES / BPW;
  localparam int NBW      = $clog2(BPW) + 1;
  localparam int BCW      = $clog2(BLKBYTES) + 1;
  localparam int WCW      = (WPB > 1) ? $clog2(WPB) : 1;

  typedef logic [BUSW-1:0] word_t;
  typedef logic [BPW-1:0]  mask_t;

  typedef enum logic {
    ST_PASS = 1'b0,
    ST_PAD  = 1'b1
  } state_e;

endpackage

// File: rtl/romulus_pdi_formatter_if.sv
// Message-in stream plus pdi word-out stream of the formatter.
// slave = formatter view; master = source/datapath view.
interface romulus_pdi_formatter_if;
  import romulus_pdi_formatter_pkg::*;

  word_t          in_data;
  logic [NBW-1:0] in_bytes;
  logic           in_last;
  logic           in_dec;
  logic           in_valid;
  logic           in_ready;
  word_t          pdi;
  mask_t          decrypt;
  logic           pdi_valid;
  logic           pdi_ready;
  logic           blk_last_word;
  logic           blk_partial;
  logic           msg_done;

  modport slave (
    input  in_data, in_bytes, in_last, in_dec, in_valid, pdi_ready,
    output in_ready, pdi, decrypt, pdi_valid, blk_last_word, blk_partial, msg_done
  );

  modport master (
    output in_data, in_bytes, in_last, in_dec, in_valid, pdi_ready,
    input  in_ready, pdi, decrypt, pdi_valid, blk_last_word, blk_partial, msg_done
  );

endinterface

// File: rtl/romulus_pdi_formatter_pad_word.sv
// Combinational: zero bytes at/after nbytes, build decrypt mask, optionally put len in the LSB byte.
// Byte 0 sits in the MSBs of the word and in the MSB of the mask.
module romulus_pad_word
  import romulus_pdi_formatter_pkg::*;
(
  input  word_t          word_i,
  input  logic [NBW-1:0] nbytes_i,
  input  logic           dec_i,
  input  logic           put_len_i,
  input  logic [BCW-1:0] len_i,
  output word_t          word_o,
  output mask_t          mask_o
);

  always_comb begin
    word_o = '0;
    mask_o = '0;
    for (int i = 0; i < BPW; i++) begin
      if (i < int'(nbytes_i)) begin
        word_o[BUSW-1-8*i -: 8] = word_i[BUSW-1-8*i -: 8];
        mask_o[BPW-1-i]         = dec_i;
      end
    end
    if (put_len_i) word_o[7:0] = 8'(len_i);
  end

endmodule

// File: rtl/romulus_pdi_formatter.sv
// Formats a byte-counted message into padded 16-byte blocks of BUSW words; one registered stage,
// accepted word appears next cycle; input stalls while the output is held or padding is emitted.
module romulus_pdi_formatter
  import romulus_pdi_formatter_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  romulus_pdi_formatter_if.slave  bus
);

  state_e         state_q, state_d;
  logic [WCW-1:0] wcnt_q, wcnt_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
  logic           seg_start_q, seg_start_d;
  logic           dec_q, dec_d;
  word_t          pdi_q, pdi_d;
  mask_t          mask_q, mask_d;
  logic           vld_q, vld_d;
  logic           blast_q, blast_d;
  logic           part_q, part_d;
  logic           done_q, done_d;

  logic           load_ok, blk_end, eff_last, dec_eff, short_word;
  logic [BCW-1:0] sum;
  word_t          pw_data, pw_word;
  logic [NBW-1:0] pw_nbytes;
  logic           pw_dec, pw_put_len;
  logic [BCW-1:0] pw_len;
  mask_t          pw_mask;

  assign load_ok      = ~vld_q | bus.pdi_ready;
  assign bus.in_ready = (state_q == ST_PASS) & load_ok;
  assign blk_end      = (wcnt_q == WCW'(WPB - 1));
  assign short_word   = (bus.in_bytes < NBW'(BPW));
  // A short word can only be the tail of a segment, whatever in_last says.
  assign eff_last     = bus.in_last | short_word;
  assign dec_eff      = seg_start_q ? bus.in_dec : dec_q;
  assign sum          = bcnt_q + BCW'(bus.in_bytes);

  always_comb begin
    pw_data    = bus.in_data;
    pw_nbytes  = bus.in_bytes;
    pw_dec     = dec_eff;
    pw_len     = sum;
    pw_put_len = eff_last & blk_end & (sum < BCW'(BLKBYTES));
    if (state_q == ST_PAD) begin
      pw_data    = '0;
      pw_nbytes  = '0;
      pw_dec     = 1'b0;
      pw_len     = bcnt_q;
      pw_put_len = blk_end;
    end
  end

  romulus_pad_word u_pad (
    .word_i    (pw_data),
    .nbytes_i  (pw_nbytes),
    .dec_i     (pw_dec),
    .put_len_i (pw_put_len),
    .len_i     (pw_len),
    .word_o    (pw_word),
    .mask_o    (pw_mask)
  );

  always_comb begin
    logic load;
    load        = 1'b0;
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    bcnt_d      = bcnt_q;
    seg_start_d = seg_start_q;
    dec_d       = dec_q;
    pdi_d       = pdi_q;
    mask_d      = mask_q;
    vld_d       = vld_q & ~bus.pdi_ready;
    blast_d     = blast_q;
    part_d      = part_q;
    done_d      = done_q;

    case (state_q)
      ST_PASS: begin
        if (bus.in_valid && bus.in_ready) begin
          load        = 1'b1;
          seg_start_d = eff_last;
          dec_d       = dec_eff;
          part_d      = eff_last & (sum < BCW'(BLKBYTES));
          done_d      = eff_last & blk_end;
          if (eff_last && !blk_end) state_d = ST_PAD;
        end
      end
      ST_PAD: begin
        if (load_ok) begin
          load   = 1'b1;
          part_d = 1'b1;
          done_d = blk_end;
          if (blk_end) state_d = ST_PASS;
        end
      end
      default: state_d = ST_PASS;
    endcase

    if (load) begin
      pdi_d   = pw_word;
      mask_d  = pw_mask;
      vld_d   = 1'b1;
      blast_d = blk_end;
      wcnt_d  = blk_end ? '0 : wcnt_q + 1'b1;
      bcnt_d  = blk_end ? '0 : pw_len;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_PASS;
      wcnt_q      <= '0;
      bcnt_q      <= '0;
      seg_start_q <= 1'b1;
      dec_q       <= 1'b0;
      pdi_q       <= '0;
      mask_q      <= '0;
      vld_q       <= 1'b0;
      blast_q     <= 1'b0;
      part_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      bcnt_q      <= bcnt_d;
      seg_start_q <= seg_start_d;
      dec_q       <= dec_d;
      pdi_q       <= pdi_d;
      mask_q      <= mask_d;
      vld_q       <= vld_d;
      blast_q     <= blast_d;
      part_q      <= part_d;
      done_q      <= done_d;
    end
  end

  assign bus.pdi           = pdi_q;
  assign bus.decrypt       = mask_q;
  assign bus.pdi_valid     = vld_q;
  assign bus.blk_last_word = blast_q;
  assign bus.blk_partial   = part_q;
  assign bus.msg_done      = done_q;

endmodule

// File: tb/tb_romulus_pdi_formatter.sv
// Bench for the PDI formatter: directed cases plus random messages against a block-level padding model.
module tb_romulus_pdi_formatter;

  typedef struct {
    logic [31:0] pdi;
    logic [3:0]  mask;
    logic        blast;
    logic        part;
    logic        done;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t exp_q[$];
  logic [7:0] msg[$];

  romulus_pdi_formatter_if bus ();

  romulus_pdi_formatter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  // Whole-message view: cut into 16-byte blocks, zero-fill, byte 15 = length of a short block.
  task automatic build_exp(input int len, input bit dec);
    int   nblk;
    int   n;
    exp_t e;
    logic [7:0] b;
    nblk = (len == 0) ? 1 : (len + 15) / 16;
    for (int blk = 0; blk < nblk; blk++) begin
      n = len - 16 * blk;
      if (n > 16) n = 16;
      for (int w = 0; w < 4; w++) begin
        e.pdi  = '0;
        e.mask = '0;
        for (int k = 0; k < 4; k++) begin
          int j;
          j = 4 * w + k;
          b = (j < n) ? msg[16 * blk + j] : 8'h00;
          if (j == 15 && n < 16) b = 8'(n);
          e.pdi[31 - 8 * k -: 8] = b;
          e.mask[3 - k] = dec && (j < n);
        end
        e.blast = (w == 3);
        e.part  = (n < 16);
        e.done  = (blk == nblk - 1) && (w == 3);
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic run_msg(input int len, input bit dec, input int rdy_pct, input int vld_pct,
                         input bit seq, input bit drop_last, input bit abort_pad);
    int   nwords;
    int   wi;
    int   cyc;
    int   nb;
    bit   pad_chk;
    bit   aborted;
    exp_t e;
    msg.delete();
    exp_q.delete();
    for (int i = 0; i < len; i++) msg.push_back(seq ? 8'(i) : 8'($urandom));
    build_exp(len, dec);
    nwords  = (len == 0) ? 1 : (len + 3) / 4;
    wi      = 0;
    cyc     = 0;
    pad_chk = 1'b0;
    aborted = 1'b0;
    while ((wi < nwords || exp_q.size() > 0) && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      bus.pdi_ready = ($urandom_range(99) < rdy_pct);
      if (wi < nwords && $urandom_range(99) < vld_pct) begin
        nb = (len == 0) ? 0 : ((len - 4 * wi > 4) ? 4 : len - 4 * wi);
        for (int k = 0; k < 4; k++) begin
          int idx;
          idx = 4 * wi + k;
          bus.in_data[31 - 8 * k -: 8] = (idx < len) ? msg[idx] : 8'($urandom);
        end
        bus.in_bytes = 3'(nb);
        bus.in_last  = (wi == nwords - 1) && !(drop_last && nb > 0 && nb < 4);
        bus.in_dec   = (wi == 0) ? dec : 1'($urandom);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (pad_chk) begin
        check("in_ready_pad", bus.in_ready, 0);
        pad_chk = 1'b0;
        if (abort_pad) begin
          aborted = 1'b1;
          break;
        end
      end
      if (bus.pdi_valid) begin
        if (exp_q.size() == 0) begin
          check("extra_word", 1, 0);
        end else begin
          e = exp_q[0];
          check("pdi", bus.pdi, e.pdi);
          check("decrypt", bus.decrypt, e.mask);
          check("blk_last_word", bus.blk_last_word, e.blast);
          check("msg_done", bus.msg_done, e.done);
          if (e.blast) check("blk_partial", bus.blk_partial, e.part);
          if (bus.pdi_ready) void'(exp_q.pop_front());
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        if (wi == nwords - 1 && ((nwords - 1) % 4) != 3) pad_chk = 1'b1;
        wi++;
      end
    end
    if (cyc >= 3000) check("timeout", 1, 0);
    if (aborted) begin
      rst          = 1'b1;
      bus.in_valid = 1'b0;
      @(negedge clk);
      #1;
      check("rst_pdi_valid", bus.pdi_valid, 0);
      rst = 1'b0;
      exp_q.delete();
    end else begin
      @(negedge clk);
      bus.in_valid  = 1'b0;
      bus.pdi_ready = 1'b0;
      #1;
      check("idle_pdi_valid", bus.pdi_valid, 0);
    end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_data   = '0;
    bus.in_bytes  = '0;
    bus.in_last   = 1'b0;
    bus.in_dec    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.pdi_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_pdi_valid", bus.pdi_valid, 0);
    check("rst_pdi", bus.pdi, 0);
    check("rst_decrypt", bus.decrypt, 0);
    check("rst_blk_last_word", bus.blk_last_word, 0);
    check("rst_blk_partial", bus.blk_partial, 0);
    check("rst_msg_done", bus.msg_done, 0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    run_msg(16, 1'b0, 100, 100, 1'b1, 1'b0, 1'b0);
    run_msg(5,  1'b0, 100, 100, 1'b1, 1'b0, 1'b0);
    run_msg(0,  1'b0, 100, 100, 1'b0, 1'b0, 1'b0);
    run_msg(6,  1'b1, 100, 100, 1'b0, 1'b0, 1'b0);
    run_msg(15, 1'b1, 100, 100, 1'b0, 1'b0, 1'b0);
    run_msg(32, 1'b0, 40,  100, 1'b0, 1'b0, 1'b0);
    run_msg(7,  1'b1, 100, 100, 1'b0, 1'b1, 1'b0);
    run_msg(5,  1'b0, 100, 100, 1'b1, 1'b0, 1'b1);
    run_msg(16, 1'b0, 100, 100, 1'b1, 1'b0, 1'b0);

    for (int m = 0; m < 40; m++) begin
      run_msg($urandom_range(0, 40), 1'($urandom), $urandom_range(30, 100),
              $urandom_range(30, 100), 1'b0, 1'($urandom), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
